yacht_turn_ctrl: RTL and testbench
==================================

# yacht_turn_ctrl

Turn and game sequencer for the Yacht Dice datapath. It owns the five dice registers, the hold mask, the roll budget, the 12-category usage mask and the running score. It drives the combinational score calculator through a dice/category interface and samples its 8-bit result once per committed turn. It sits between the debounced board inputs and the display/score logic, and it ends the game after 12 scored rounds.

## Interface
- No parameters. LFSR seed is fixed at 16'hACE1; rounds per game are fixed at 12.
- clk  in  1  single system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begin a new game (restarts from any state)
- roll  in  1  one-cycle pulse; roll the dice that are not held
- hold_toggle  in  5  one-cycle pulses; bit i inverts the hold flag of die i
- cat_sel  in  4  requested category, 0–11
- cat_commit  in  1  one-cycle pulse; score the current dice into cat_sel
- dbg_load  in  1  test hook; force all dice to dbg_dice
- dbg_dice  in  15  {d5,d4,d3,d2,d1}, each 3 bits, values 1–6
- score_in  in  8  score-calculator result for d1..d5 and calc_cat
- d1, d2, d3, d4, d5  out  3 each  current dice; value 0 means not yet rolled
- calc_cat  out  4  category presented to the score calculator
- held  out  5  hold mask
- rolls_left  out  2  rolls remaining this round (3..0)
- round  out  4  current round, 1–12; 0 when idle
- used  out  12  category used mask; bit k means category k has been scored
- upper_sum  out  7  sum of scores in categories 0–5 (maximum 105)
- total  out  9  game total including bonus (maximum 345)
- bonus  out  1  upper bonus has been awarded
- commit_ok, commit_err  out  1 each  one-cycle status pulses
- game_over  out  1  high in the OVER state

## Operation
- States are IDLE, WAIT_ROLL, ROLLED, SCORE and OVER. Reset enters IDLE.
- Reset values: every output is 0, and the LFSR is 16'hACE1.
- The LFSR advances every cycle in all states. Update rule: lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
- Die value on a roll: die i (i = 0..4) takes r = lfsr[3i+2:3i] and sets value = (r mod 6) + 1. So r = 6 gives 1 and r = 7 gives 2.
- start is accepted in any state and has top priority. It clears dice, held, used, upper_sum, total and bonus. It sets round = 1 and rolls_left = 3, then goes to WAIT_ROLL.
- WAIT_ROLL:
  - roll loads all five dice from the LFSR, decrements rolls_left and goes to ROLLED.
  - dbg_load loads dbg_dice, leaves rolls_left unchanged and goes to ROLLED.
  - hold_toggle and cat_commit are ignored.
- ROLLED, in priority order start > cat_commit > dbg_load > roll:
  - cat_commit with cat_sel > 11, or with used[cat_sel] = 1: pulse commit_err and stay in ROLLED.
  - cat_commit otherwise: register calc_cat = cat_sel and go to SCORE. Any roll in the same cycle is dropped.
  - dbg_load overwrites all dice.
  - roll with rolls_left > 0 rerolls only dice whose held bit is 0 (using the held value registered before this edge), then decrements rolls_left.
  - roll with rolls_left = 0 is ignored.
  - hold_toggle is applied as held ^= hold_toggle in any ROLLED cycle that is not a commit cycle.
- SCORE lasts exactly one cycle. score_in is valid here because dice and calc_cat are registered and the calculator is combinational.
  - Let s = score_in.
  - If calc_cat ≤ 5: u = upper_sum + s, and upper_sum <= u.
  - If calc_cat ≤ 5, bonus = 0 and u ≥ 63: total <= total + s + 35 and bonus <= 1. Otherwise total <= total + s.
  - Set used[calc_cat] and pulse commit_ok.
  - If round = 12, go to OVER. Otherwise increment round, set rolls_left = 3, held = 0 and dice = 0, and go to WAIT_ROLL.
- OVER: game_over = 1 and all inputs except start are ignored. Dice, used, upper_sum and total hold their values.
- Width rules: all additions are unsigned and cannot overflow at the stated widths.

## Timing
- Outputs are registered, with no combinational input-to-output paths. calc_cat is the only signal the calculator reads besides the dice.
- roll sampled at edge T: new dice and rolls_left are visible after edge T.
- cat_commit sampled at edge T:
  - SCORE is active during cycle T+1.
  - total, upper_sum, used, bonus and commit_ok all update at edge T+1.
  - commit_ok is high for exactly the one cycle after edge T+1.
- commit_err is high for the one cycle after the rejecting edge.
- Back-to-back pulses are accepted on consecutive cycles. A roll arriving during the SCORE cycle is ignored.
- rst_n assertion at any point, including during SCORE, clears everything immediately. A partially scored turn is never committed.

## Test plan
- Reset: hold rst_n low mid-game → all outputs 0. First LFSR roll after start plus N cycles matches the reference LFSR model.
- Hold and reroll:
  - Stimulus: dbg_load 15'b110_101_100_011_010 (d1..d5 = 2,3,4,5,6), toggle holds 5'b00011, then three rolls.
  - Required: d1 = 2 and d2 = 3 are unchanged; rolls_left goes 3, 2, 1, 0; a fourth roll is ignored.
- Large straight:
  - Stimulus: dice 2,3,4,5,6 with score model returning 40, then commit cat 10.
  - Required: total = 40, used = 12'h400, round = 2.
  - Then recommit cat 10 in round 2 → commit_err; total stays 40.
- Bonus:
  - Stimulus: score categories 3, 4 and 5 with scores 16, 20 and 30.
  - Required: upper_sum = 66, bonus = 1 set on the third commit, total = 101.
  - Then score 0 in cat 0 → total stays 101 and the bonus is not re-awarded.
- Full game: 12 valid commits → game_over = 1 after the 12th SCORE, used = 12'hFFF, and roll/commit are ignored.
- Restart and conflicts:
  - start mid-round 7 → round = 1 and all score state is cleared.
  - cat_commit and roll in the same cycle → committed, and the dice are unchanged by the roll.

Source files
------------

// File: rtl/yacht_turn_ctrl_if.sv
// Board-input / display-output bundle for the Yacht turn sequencer, including the
// dice/category link to the combinational score calculator.
interface yacht_turn_ctrl_if;
    logic        start;
    logic        roll;
    logic [4:0]  hold_toggle;
    logic [3:0]  cat_sel;
    logic        cat_commit;
    logic        dbg_load;
    logic [14:0] dbg_dice;
    logic [7:0]  score_in;

    logic [2:0]  d1, d2, d3, d4, d5;
    logic [3:0]  calc_cat;
    logic [4:0]  held;
    logic [1:0]  rolls_left;
    logic [3:0]  round;
    logic [11:0] used;
    logic [6:0]  upper_sum;
    logic [8:0]  total;
    logic        bonus;
    logic        commit_ok;
    logic        commit_err;
    logic        game_over;

    // Sequencer side
    modport slave (
        input  start, roll, hold_toggle, cat_sel, cat_commit, dbg_load, dbg_dice, score_in,
        output d1, d2, d3, d4, d5, calc_cat, held, rolls_left, round, used, upper_sum,
        output total, bonus, commit_ok, commit_err, game_over
    );

    // Board / calculator / display side
    modport master (
        output start, roll, hold_toggle, cat_sel, cat_commit, dbg_load, dbg_dice, score_in,
        input  d1, d2, d3, d4, d5, calc_cat, held, rolls_left, round, used, upper_sum,
        input  total, bonus, commit_ok, commit_err, game_over
    );
endinterface

// File: rtl/yacht_turn_ctrl.sv
// Turn and game sequencer for Yacht: owns dice, hold mask, roll budget, category
// usage and running score; samples the external score calculator once per commit.
module yacht_turn_ctrl (
    input logic              clk,
    input logic              rst_n,
    yacht_turn_ctrl_if.slave bus
);
    typedef enum logic [2:0] {StIdle, StWaitRoll, StRolled, StScore, StOver} state_e;

    state_e           state_q, state_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [4:0][2:0]  dice_q, dice_d;
    logic [4:0]       held_q, held_d;
    logic [1:0]       rolls_left_q, rolls_left_d;
    logic [3:0]       round_q, round_d;
    logic [11:0]      used_q, used_d;
    logic [6:0]       upper_sum_q, upper_sum_d;
    logic [8:0]       total_q, total_d;
    logic             bonus_q, bonus_d;
    logic [3:0]       calc_cat_q, calc_cat_d;
    logic             commit_ok_q, commit_ok_d;
    logic             commit_err_q, commit_err_d;

    logic [4:0][2:0]  rolled;
    logic [15:0]      used_ext;
    logic             cat_ok;
    logic [8:0]       upper_new;
    logic [8:0]       total_plain;

    // Map a 3-bit LFSR field onto 1..6 (6 -> 1, 7 -> 2)
    function automatic logic [2:0] die_from(input logic [2:0] r);
        return (r >= 3'd6) ? (r - 3'd5) : (r + 3'd1);
    endfunction

    // Candidate die values from the current LFSR state
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            rolled[i] = die_from(lfsr_q[3*i +: 3]);
        end
    end

    // Zero-extended so an out-of-range cat_sel indexes a cleared bit
    assign used_ext    = {4'b0, used_q};
    assign cat_ok      = (bus.cat_sel <= 4'd11) && !used_ext[bus.cat_sel];
    assign upper_new   = {2'b0, upper_sum_q} + {1'b0, bus.score_in};
    assign total_plain = total_q + {1'b0, bus.score_in};

    // Next-state and datapath update
    always_comb begin
        state_d      = state_q;
        lfsr_d       = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        dice_d       = dice_q;
        held_d       = held_q;
        rolls_left_d = rolls_left_q;
        round_d      = round_q;
        used_d       = used_q;
        upper_sum_d  = upper_sum_q;
        total_d      = total_q;
        bonus_d      = bonus_q;
        calc_cat_d   = calc_cat_q;
        commit_ok_d  = 1'b0;
        commit_err_d = 1'b0;

        if (bus.start) begin
            dice_d       = '0;
            held_d       = '0;
            used_d       = '0;
            upper_sum_d  = '0;
            total_d      = '0;
            bonus_d      = 1'b0;
            round_d      = 4'd1;
            rolls_left_d = 2'd3;
            state_d      = StWaitRoll;
        end else begin
            unique case (state_q)
                StWaitRoll: begin
                    if (bus.dbg_load) begin
                        dice_d  = bus.dbg_dice;
                        state_d = StRolled;
                    end else if (bus.roll) begin
                        dice_d       = rolled;
                        rolls_left_d = rolls_left_q - 2'd1;
                        state_d      = StRolled;
                    end
                end
                StRolled: begin
                    if (bus.cat_commit) begin
                        if (cat_ok) begin
                            calc_cat_d = bus.cat_sel;
                            state_d    = StScore;
                        end else begin
                            commit_err_d = 1'b1;
                        end
                    end else begin
                        held_d = held_q ^ bus.hold_toggle;
                        if (bus.dbg_load) begin
                            dice_d = bus.dbg_dice;
                        end else if (bus.roll && (rolls_left_q != 2'd0)) begin
                            for (int i = 0; i < 5; i++) begin
                                if (!held_q[i]) dice_d[i] = rolled[i];
                            end
                            rolls_left_d = rolls_left_q - 2'd1;
                        end
                    end
                end
                StScore: begin
                    total_d = total_plain;
                    if (calc_cat_q <= 4'd5) begin
                        upper_sum_d = upper_new[6:0];
                        if (!bonus_q && (upper_new >= 9'd63)) begin
                            total_d = total_plain + 9'd35;
                            bonus_d = 1'b1;
                        end
                    end
                    used_d      = used_q | (12'd1 << calc_cat_q);
                    commit_ok_d = 1'b1;
                    if (round_q == 4'd12) begin
                        state_d = StOver;
                    end else begin
                        round_d      = round_q + 4'd1;
                        rolls_left_d = 2'd3;
                        held_d       = '0;
                        dice_d       = '0;
                        state_d      = StWaitRoll;
                    end
                end
                StIdle, StOver: ;
                default: state_d = StIdle;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            lfsr_q       <= 16'hACE1;
            dice_q       <= '0;
            held_q       <= '0;
            rolls_left_q <= '0;
            round_q      <= '0;
            used_q       <= '0;
            upper_sum_q  <= '0;
            total_q      <= '0;
            bonus_q      <= 1'b0;
            calc_cat_q   <= '0;
            commit_ok_q  <= 1'b0;
            commit_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            dice_q       <= dice_d;
            held_q       <= held_d;
            rolls_left_q <= rolls_left_d;
            round_q      <= round_d;
            used_q       <= used_d;
            upper_sum_q  <= upper_sum_d;
            total_q      <= total_d;
            bonus_q      <= bonus_d;
            calc_cat_q   <= calc_cat_d;
            commit_ok_q  <= commit_ok_d;
            commit_err_q <= commit_err_d;
        end
    end

    assign bus.d1         = dice_q[0];
    assign bus.d2         = dice_q[1];
    assign bus.d3         = dice_q[2];
    assign bus.d4         = dice_q[3];
    assign bus.d5         = dice_q[4];
    assign bus.calc_cat   = calc_cat_q;
    assign bus.held       = held_q;
    assign bus.rolls_left = rolls_left_q;
    assign bus.round      = round_q;
    assign bus.used       = used_q;
    assign bus.upper_sum  = upper_sum_q;
    assign bus.total      = total_q;
    assign bus.bonus      = bonus_q;
    assign bus.commit_ok  = commit_ok_q;
    assign bus.commit_err = commit_err_q;
    assign bus.game_over  = (state_q == StOver);
endmodule

// File: tb/tb_yacht_turn_ctrl.sv
// Directed bench for yacht_turn_ctrl with a reference LFSR model.
module tb_yacht_turn_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    yacht_turn_ctrl_if bus ();

    yacht_turn_ctrl dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0]     ref_lfsr;
    logic [4:0][2:0] exp_dice;

    localparam logic [14:0] Straight = 15'b110_101_100_011_010;

    // Reference LFSR, free-running from reset
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ref_lfsr <= 16'hACE1;
        else ref_lfsr <= {ref_lfsr[14:0], ref_lfsr[15] ^ ref_lfsr[13] ^ ref_lfsr[12] ^ ref_lfsr[10]};
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] ref_die(input logic [2:0] r);
        int v;
        v = (int'(r) % 6) + 1;
        return v[2:0];
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_dice(input string tag, input logic [4:0][2:0] exp);
        logic [4:0][2:0] got;
        got = {bus.d5, bus.d4, bus.d3, bus.d2, bus.d1};
        for (int i = 0; i < 5; i++) check_eq($sformatf("%s_d%0d", tag, i + 1), got[i], exp[i]);
    endtask

    task automatic check_reset(input string tag);
        check_dice({tag, "_dice"}, '0);
        check_eq({tag, "_held"}, bus.held, 0);
        check_eq({tag, "_rolls"}, bus.rolls_left, 0);
        check_eq({tag, "_round"}, bus.round, 0);
        check_eq({tag, "_used"}, bus.used, 0);
        check_eq({tag, "_upper"}, bus.upper_sum, 0);
        check_eq({tag, "_total"}, bus.total, 0);
        check_eq({tag, "_bonus"}, bus.bonus, 0);
        check_eq({tag, "_ok"}, bus.commit_ok, 0);
        check_eq({tag, "_err"}, bus.commit_err, 0);
        check_eq({tag, "_over"}, bus.game_over, 0);
        check_eq({tag, "_calc_cat"}, bus.calc_cat, 0);
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic do_load(input logic [14:0] v);
        bus.dbg_load = 1'b1;
        bus.dbg_dice = v;
        tick();
        bus.dbg_load = 1'b0;
    endtask

    task automatic do_roll();
        bus.roll = 1'b1;
        tick();
        bus.roll = 1'b0;
    endtask

    // Roll and compare against the reference LFSR value seen by the sampling edge
    task automatic roll_checked(input string tag, input logic [4:0] hmask,
                                input logic [1:0] exp_rolls);
        logic [15:0] snap;
        snap = ref_lfsr;
        do_roll();
        for (int i = 0; i < 5; i++) if (!hmask[i]) exp_dice[i] = ref_die(snap[3*i +: 3]);
        check_dice(tag, exp_dice);
        check_eq({tag, "_rolls"}, bus.rolls_left, exp_rolls);
    endtask

    task automatic do_commit(input logic [3:0] cat, input logic [7:0] score);
        bus.cat_sel    = cat;
        bus.cat_commit = 1'b1;
        tick();
        bus.cat_commit = 1'b0;
        bus.score_in   = score;
        tick();
        check_eq($sformatf("commit_ok_cat%0d", cat), bus.commit_ok, 1);
    endtask

    task automatic play_round(input logic [3:0] cat, input logic [7:0] score);
        do_roll();
        do_commit(cat, score);
    endtask

    initial begin
        bus.start = 0; bus.roll = 0; bus.hold_toggle = 0; bus.cat_sel = 0;
        bus.cat_commit = 0; bus.dbg_load = 0; bus.dbg_dice = 0; bus.score_in = 0;
        exp_dice = '0;
        repeat (2) tick();
        check_reset("por");
        rst_n = 1'b1;

        // First roll after start plus a few idle cycles
        repeat (5) tick();
        do_start();
        check_eq("start_round", bus.round, 1);
        check_eq("start_rolls", bus.rolls_left, 3);
        roll_checked("first_roll", 5'b00000, 2'd2);

        // Mid-game asynchronous reset
        bus.hold_toggle = 5'b10101;
        tick();
        bus.hold_toggle = 0;
        rst_n = 1'b0;
        #1;
        check_reset("mid_reset");
        tick();
        rst_n = 1'b1;

        // Hold and reroll
        repeat (3) tick();
        do_start();
        do_load(Straight);
        exp_dice = Straight;
        check_dice("load", exp_dice);
        check_eq("load_rolls", bus.rolls_left, 3);
        bus.hold_toggle = 5'b00011;
        tick();
        bus.hold_toggle = 0;
        check_eq("held", bus.held, 5'b00011);
        roll_checked("reroll1", 5'b00011, 2'd2);
        roll_checked("reroll2", 5'b00011, 2'd1);
        roll_checked("reroll3", 5'b00011, 2'd0);
        do_roll();
        check_dice("roll4_ignored", exp_dice);
        check_eq("roll4_rolls", bus.rolls_left, 0);

        // Large straight, then a duplicate and an out-of-range category
        do_load(Straight);
        do_commit(4'd10, 8'd40);
        check_eq("ls_total", bus.total, 40);
        check_eq("ls_used", bus.used, 12'h400);
        check_eq("ls_round", bus.round, 2);
        check_eq("ls_rolls", bus.rolls_left, 3);
        check_eq("ls_held", bus.held, 0);
        check_dice("ls_cleared", '0);
        do_roll();
        bus.cat_sel = 4'd10;
        bus.cat_commit = 1'b1;
        tick();
        bus.cat_commit = 1'b0;
        check_eq("dup_err", bus.commit_err, 1);
        check_eq("dup_ok", bus.commit_ok, 0);
        tick();
        check_eq("dup_err_pulse", bus.commit_err, 0);
        check_eq("dup_total", bus.total, 40);
        check_eq("dup_used", bus.used, 12'h400);
        bus.cat_sel = 4'd12;
        bus.cat_commit = 1'b1;
        tick();
        bus.cat_commit = 1'b0;
        check_eq("cat12_err", bus.commit_err, 1);

        // Bonus, then the rest of a full game
        do_start();
        play_round(4'd3, 8'd16);
        check_eq("b1_upper", bus.upper_sum, 16);
        play_round(4'd4, 8'd20);
        check_eq("b2_upper", bus.upper_sum, 36);
        check_eq("b2_bonus", bus.bonus, 0);
        check_eq("b2_total", bus.total, 36);
        play_round(4'd5, 8'd30);
        check_eq("b3_upper", bus.upper_sum, 66);
        check_eq("b3_bonus", bus.bonus, 1);
        check_eq("b3_total", bus.total, 101);
        play_round(4'd0, 8'd0);
        check_eq("b4_total", bus.total, 101);
        check_eq("b4_bonus", bus.bonus, 1);
        check_eq("b4_used", bus.used, 12'h039);
        check_eq("b4_round", bus.round, 5);
        play_round(4'd1, 8'd4);
        play_round(4'd2, 8'd6);
        play_round(4'd6, 8'd10);
        play_round(4'd7, 8'd12);
        play_round(4'd8, 8'd25);
        play_round(4'd9, 8'd30);
        play_round(4'd10, 8'd40);
        check_eq("r12_round", bus.round, 12);
        check_eq("r12_over", bus.game_over, 0);
        play_round(4'd11, 8'd50);
        check_eq("end_over", bus.game_over, 1);
        check_eq("end_used", bus.used, 12'hFFF);
        check_eq("end_total", bus.total, 278);
        check_eq("end_upper", bus.upper_sum, 76);
        check_eq("end_round", bus.round, 12);
        do_roll();
        check_eq("over_roll_rolls", bus.rolls_left, 2);
        bus.cat_sel = 4'd0;
        bus.cat_commit = 1'b1;
        tick();
        bus.cat_commit = 1'b0;
        check_eq("over_commit_ok", bus.commit_ok, 0);
        check_eq("over_commit_err", bus.commit_err, 0);
        tick();
        check_eq("over_total", bus.total, 278);
        check_eq("over_still", bus.game_over, 1);

        // Restart in round 7
        do_start();
        for (int c = 0; c < 6; c++) play_round(4'(c), 8'd1);
        check_eq("r7_round", bus.round, 7);
        do_roll();
        do_start();
        check_eq("rs_round", bus.round, 1);
        check_eq("rs_used", bus.used, 0);
        check_eq("rs_total", bus.total, 0);
        check_eq("rs_upper", bus.upper_sum, 0);
        check_eq("rs_bonus", bus.bonus, 0);
        check_eq("rs_rolls", bus.rolls_left, 3);
        check_eq("rs_over", bus.game_over, 0);
        check_dice("rs_dice", '0);

        // Commit and roll in the same cycle: commit wins, dice untouched
        do_roll();
        do_load(Straight);
        exp_dice = Straight;
        bus.cat_sel = 4'd11;
        bus.cat_commit = 1'b1;
        bus.roll = 1'b1;
        tick();
        bus.cat_commit = 1'b0;
        bus.roll = 1'b0;
        check_dice("conflict", exp_dice);
        check_eq("conflict_rolls", bus.rolls_left, 2);
        check_eq("conflict_calc_cat", bus.calc_cat, 11);
        bus.score_in = 8'd50;
        tick();
        check_eq("conflict_ok", bus.commit_ok, 1);
        check_eq("conflict_total", bus.total, 50);
        check_eq("conflict_used", bus.used, 12'h800);
        check_eq("conflict_round", bus.round, 2);
        tick();
        check_eq("ok_pulse", bus.commit_ok, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
